// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: receive-side checker for the VGA output path.
// Recovers pixel/line position from hsync/vsync on pix_tick strobes, measures
// line and frame lengths, locks onto valid timing, flags sticky timing errors
// and publishes a CRC-16-CCITT signature of the active pixels of each locked frame.
// Optional build macro VGA_MON_LIT_COUNT_EN adds lit_count, the number of
// non-black active pixels in the last locked frame.
//
// state  | meaning
// SEARCH | no timing reference, waiting for a frame event
// ALIGN  | measuring one whole frame, it must be error-free to lock
// LOCKED | timing verified, frame CRC and count published each frame
`timescale 1ns/1ps
module vga_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    input  logic        clr_err,
    output logic        locked,
    output logic [9:0]  rec_x,
    output logic [9:0]  rec_y,
    output logic        rec_active,
    output logic [10:0] h_total_meas,
    output logic [10:0] v_total_meas,
    output logic        err_h,
    output logic        err_v,
    output logic [15:0] frame_count,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`ifdef VGA_MON_LIT_COUNT_EN
    ,
    output logic [18:0] lit_count
`endif
);

    localparam logic [10:0] H_TOT_C  = 11'(H_TOTAL);
    localparam logic [10:0] H_SYNC_C = 11'(H_SYNC);
    localparam logic [10:0] V_TOT_C  = 11'(V_TOTAL);
    localparam logic [10:0] H_FIRST  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_LAST   = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [10:0] V_FIRST  = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_LAST   = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t      state, state_nxt;
    logic        frame_err, frame_err_nxt;
    logic        hsync_prev, vsync_prev;
    logic [10:0] hcount, vcount;
    logic [15:0] crc;

    logic        h_fall, h_rise, f_evt;
    logic [10:0] h_len, v_len, hcount_nxt, vcount_nxt;
    logic        err_h_now, err_v_now, err_now;
    logic        pix_active, crc_emit;
    logic [15:0] crc_next;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // Shifts 12 data bits MSB first through CRC-16-CCITT (poly 0x1021).
    function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Tick-qualified sync edges, position update, error conditions and next state.
    always_comb begin
        h_fall     = pix_tick & hsync_prev & ~hsync;
        h_rise     = pix_tick & ~hsync_prev & hsync;
        f_evt      = h_fall & vsync_prev & ~vsync;
        h_len      = sat_inc(hcount);
        v_len      = sat_inc(vcount);
        hcount_nxt = h_fall ? 11'd0 : h_len;
        vcount_nxt = f_evt ? 11'd0 : (h_fall ? v_len : vcount);
        err_h_now  = (state != SEARCH) &
                     ((h_fall & (h_len != H_TOT_C)) | (h_rise & (h_len != H_SYNC_C)));
        err_v_now  = (state != SEARCH) & f_evt & (v_len != V_TOT_C);
        err_now    = err_h_now | err_v_now;
        pix_active = (hcount_nxt >= H_FIRST) && (hcount_nxt <= H_LAST) &&
                     (vcount_nxt >= V_FIRST) && (vcount_nxt <= V_LAST);
        crc_next   = crc12(crc, {vga_r, vga_g, vga_b});
        crc_emit   = f_evt & (state == LOCKED) & ~err_now;

        state_nxt     = state;
        frame_err_nxt = frame_err;
        case (state)
            SEARCH: begin
                if (f_evt) begin
                    state_nxt     = ALIGN;
                    frame_err_nxt = 1'b0;
                end
            end
            ALIGN: begin
                if (f_evt) begin
                    state_nxt     = (frame_err | err_now) ? ALIGN : LOCKED;
                    frame_err_nxt = 1'b0;
                end else if (err_now) begin
                    frame_err_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (err_now) state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // State, counters, CRC and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SEARCH;
            frame_err    <= 1'b0;
            hsync_prev   <= 1'b1;
            vsync_prev   <= 1'b1;
            hcount       <= '0;
            vcount       <= '0;
            crc          <= '0;
            locked       <= 1'b0;
            rec_x        <= '0;
            rec_y        <= '0;
            rec_active   <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            err_h        <= 1'b0;
            err_v        <= 1'b0;
            frame_count  <= '0;
            frame_crc    <= '0;
            crc_valid    <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_err <= frame_err_nxt;
            locked    <= (state_nxt == LOCKED);
            crc_valid <= crc_emit;
            // a fresh error beats a simultaneous clear
            err_h     <= (err_h & ~clr_err) | err_h_now;
            err_v     <= (err_v & ~clr_err) | err_v_now;
            if (pix_tick) begin
                hsync_prev <= hsync;
                hcount     <= hcount_nxt;
                vcount     <= vcount_nxt;
                rec_active <= pix_active;
                rec_x      <= pix_active ? 10'(hcount_nxt - H_FIRST) : 10'd0;
                rec_y      <= pix_active ? 10'(vcount_nxt - V_FIRST) : 10'd0;
                if (h_fall) begin
                    vsync_prev   <= vsync;
                    h_total_meas <= h_len;
                end
                if (f_evt) begin
                    v_total_meas <= v_len;
                    crc          <= 16'hFFFF;
                end else if (pix_active) begin
                    crc <= crc_next;
                end
                if (crc_emit) begin
                    frame_crc   <= crc;
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

`ifdef VGA_MON_LIT_COUNT_EN
    logic [18:0] lit_acc;

    // Counts non-black active pixels per frame, published with the frame CRC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lit_acc   <= '0;
            lit_count <= '0;
        end else begin
            if (f_evt)
                lit_acc <= '0;
            else if (pix_tick && pix_active && ({vga_r, vga_g, vga_b} != 12'd0))
                lit_acc <= lit_acc + 19'd1;
            if (crc_emit)
                lit_count <= lit_acc;
        end
    end
`else
    // Without the lit counter the colour inputs only feed the CRC.
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Testbench for vga_frame_monitor with scaled-down timing. A frame generator
// drives hsync/vsync/rgb, a frame-level reference model predicts lock state,
// sticky errors and measurements, and expected CRC publications are queued
// for a monitor that checks them whenever crc_valid pulses.
`timescale 1ns/1ps
module tb_vga_frame_monitor;

    localparam int HA = 16, HS = 4, HB = 3, HT = 26;
    localparam int VA = 10, VS = 2, VB = 2, VT = 16;

    logic        clk = 1'b0;
    logic        reset, pix_tick, hsync, vsync, clr_err;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        locked, rec_active, err_h, err_v, crc_valid;
    logic [9:0]  rec_x, rec_y;
    logic [10:0] h_total_meas, v_total_meas;
    logic [15:0] frame_count, frame_crc;
`ifdef VGA_MON_LIT_COUNT_EN
    logic [18:0] lit_count;
`endif

    vga_frame_monitor #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .clr_err(clr_err),
        .locked(locked), .rec_x(rec_x), .rec_y(rec_y), .rec_active(rec_active),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
        .err_h(err_h), .err_v(err_v), .frame_count(frame_count),
        .frame_crc(frame_crc), .crc_valid(crc_valid)
`ifdef VGA_MON_LIT_COUNT_EN
        , .lit_count(lit_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] crc;
        logic [15:0] cnt;
        logic [18:0] lit;
    } exp_t;
    exp_t sb[$];

    // frame-level reference model: 0 = searching, 1 = aligning, 2 = locked
    int          m_state = 0;
    bit          m_frame_bad = 0;
    bit          m_err_h = 0, m_err_v = 0;
    int          m_count = 0;
    bit          pos_ok = 0, v_ok = 0, h_ok = 0;
    int          prev_lines = 0;
    logic [15:0] prev_crc = 16'h0;
    int          prev_lit = 0;
    bit          fbits[$];
    int          flit = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_of_frame();
        logic [15:0] c;
        bit fb;
        c = 16'hFFFF;
        foreach (fbits[i]) begin
            fb = c[15] ^ fbits[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Scoreboard monitor: every crc_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && crc_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_crc_valid: got crc 0x%0h count %0d, expected no pulse",
                         frame_crc, frame_count);
            end else begin
                e = sb.pop_front();
                chk("frame_crc", 32'(frame_crc), 32'(e.crc));
                chk("frame_count_at_valid", 32'(frame_count), 32'(e.cnt));
`ifdef VGA_MON_LIT_COUNT_EN
                chk("lit_count", 32'(lit_count), 32'(e.lit));
`endif
            end
        end
    end

    task automatic do_tick(input logic hs, input logic vs, input logic [11:0] rgb, input logic clr);
        repeat (3) @(posedge clk);
        #1;
        hsync = hs;
        vsync = vs;
        {vga_r, vga_g, vga_b} = rgb;
        clr_err  = clr;
        pix_tick = 1'b1;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_rec"}, {11'd0, rec_active, rec_x, rec_y}, 0);
        chk({tag, "_meas"}, {10'd0, h_total_meas, v_total_meas}, 0);
        chk({tag, "_err"}, {30'd0, err_h, err_v}, 0);
        chk({tag, "_count_crc"}, {frame_count, frame_crc}, 0);
        chk({tag, "_crc_valid"}, 32'(crc_valid), 0);
    endtask

    task automatic frame_event_model();
        bit   len_bad;
        exp_t e;
        len_bad = (prev_lines != VT);
        if (m_state == 0) begin
            m_state     = 1;
            m_frame_bad = 0;
        end else if (m_state == 1) begin
            if (len_bad) m_err_v = 1;
            m_state     = (m_frame_bad || len_bad) ? 1 : 2;
            m_frame_bad = 0;
        end else if (len_bad) begin
            m_err_v = 1;
            m_state = 0;
        end else begin
            m_count = (m_count + 1) % 65536;
            e.crc = prev_crc;
            e.cnt = 16'(m_count);
            e.lit = 19'(prev_lit);
            sb.push_back(e);
        end
        chk("locked_at_frame", 32'(locked), 32'(m_state == 2));
        chk("err_h_at_frame", 32'(err_h), 32'(m_err_h));
        chk("err_v_at_frame", 32'(err_v), 32'(m_err_v));
        chk("frame_count", 32'(frame_count), 32'(m_count));
        if (v_ok) chk("v_total_meas", 32'(v_total_meas), 32'(prev_lines));
        if (h_ok) chk("h_total_meas", 32'(h_total_meas), HT);
        v_ok   = 1;
        h_ok   = 1;
        pos_ok = 1;
    endtask

    task automatic reset_mid();
        #2 reset = 1'b1;
        #1 check_zero("mid_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        m_state = 0; m_frame_bad = 0; m_err_h = 0; m_err_v = 0; m_count = 0;
        pos_ok = 0; v_ok = 0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        m_err_h = 0;
        m_err_v = 0;
        chk("err_h_after_clr", 32'(err_h), 0);
        chk("err_v_after_clr", 32'(err_v), 0);
    endtask

    // pmode: 0 random, 1 all black, 2 exactly 100 lit active pixels
    task automatic send_frame(input int nlines, input int pmode, input int short_line,
                              input int short_hs_line, input bit clr_at_err, input int reset_line);
        int          lit_idx, len, hsw, ex, ey;
        bit          act, err_here;
        logic [11:0] rgb;
        lit_idx = 0;
        fbits.delete();
        flit = 0;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? HT - 1 : HT;
            hsw = (l == short_hs_line) ? HS - 1 : HS;
            for (int p = 0; p < len; p++) begin
                act = (p >= HS + HB) && (p < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
                err_here = (short_line >= 0 && l == short_line + 1 && p == 0) ||
                           (l == short_hs_line && p == hsw);
                rgb = 12'($urandom_range(0, 4095));
                if (act) begin
                    if (pmode == 1) rgb = 12'd0;
                    else if (pmode == 2) rgb = (lit_idx < 100) ? 12'($urandom_range(1, 4095)) : 12'd0;
                    lit_idx++;
                    for (int b = 11; b >= 0; b--) fbits.push_back(rgb[b]);
                    if (rgb != 12'd0) flit++;
                end
                do_tick(p >= hsw, l >= VS, rgb, clr_at_err && err_here);
                if (l == 0 && p == 0) frame_event_model();
                if (err_here) begin
                    if (clr_at_err) m_err_v = 0;
                    if (m_state != 0) begin
                        m_err_h = 1;
                        if (m_state == 2) m_state = 0;
                        else m_frame_bad = 1;
                    end
                    chk("err_h_at_error", 32'(err_h), 32'(m_err_h));
                    chk("locked_at_error", 32'(locked), 32'(m_state == 2));
                end
                if (pos_ok) begin
                    ex = act ? p - (HS + HB) : 0;
                    ey = act ? l - (VS + VB) : 0;
                    chk("rec_active", 32'(rec_active), 32'(act));
                    chk("rec_xy", {6'd0, rec_x, 6'd0, rec_y}, {6'd0, 10'(ex), 6'd0, 10'(ey)});
                end
                if (l == reset_line && p == HS + HB + 5) reset_mid();
            end
        end
        prev_lines = nlines;
        prev_crc   = crc_of_frame();
        prev_lit   = flit;
    endtask

    initial begin
        reset = 1'b1; pix_tick = 1'b0; hsync = 1'b1; vsync = 1'b1; clr_err = 1'b0;
        vga_r = 4'd0; vga_g = 4'd0; vga_b = 4'd0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        reset = 1'b0;

        send_frame(VT, 0, -1, -1, 0, -1);   // F1: search -> align
        send_frame(VT, 1, -1, -1, 0, -1);   // F2: locks at its first tick
        send_frame(VT, 1, -1, -1, 0, -1);   // F3: publishes black F2
        send_frame(VT, 0, -1, -1, 0, -1);   // F4: publishes black F3
        send_frame(VT, 0, 5, -1, 0, -1);    // F5: short line drops lock
        send_frame(VT, 0, -1, -1, 0, -1);   // F6
        send_frame(VT, 0, -1, -1, 0, -1);   // F7: relocked
        send_frame(VT, 0, -1, -1, 0, -1);   // F8
        chk("err_h_sticky", 32'(err_h), 1);
        pulse_clr();
        send_frame(VT, 0, -1, 4, 1, -1);    // F9: short hsync plus clear in same cycle
        send_frame(VT, 0, -1, -1, 0, -1);   // F10
        send_frame(VT - 1, 0, -1, -1, 0, -1); // F11: locked, one line short
        send_frame(VT, 0, -1, -1, 0, -1);   // F12: frame length error
        send_frame(VT, 0, -1, -1, 0, -1);   // F13
        send_frame(VT, 2, -1, -1, 0, -1);   // F14: 100 lit pixels, locked
        send_frame(VT, 0, -1, -1, 0, 8);    // F15: reset mid active line
        send_frame(VT, 0, -1, -1, 0, -1);   // F16: align again
        send_frame(VT, 0, -1, -1, 0, -1);   // F17: relocked
        send_frame(VT, 0, -1, -1, 0, -1);   // F18: publishes F17

        repeat (8) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
